// File: rtl/stable_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stable_mon_pkg
// Description : Shared types, constants and helpers for stable_hold_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package stable_mon_pkg;

    // Monitor sequencing states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A window of zero means the check never times out
    localparam int c_WINDOW_UNLIMITED = 0;

    // Increment value, holding at the all-ones value of a 'width'-bit field
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] w_max;
        w_max = 32'hFFFF_FFFF >> (32 - width);
        return (value == w_max) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stable_hold_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : stable_hold_monitor_if
// Description : Control, sampled signal and result bundle of the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface stable_hold_monitor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] hold_cycles;
    logic [CNT_W-1:0] window_cycles;
    logic [WIDTH-1:0] sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic             change_pulse;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    // Bench / requester side
    modport master (
        output start, hold_cycles, window_cycles, sig,
        input  busy, done, pass, change_pulse, run_len, pass_cnt, fail_cnt
    );

    // Monitor side
    modport slave (
        input  start, hold_cycles, window_cycles, sig,
        output busy, done, pass, change_pulse, run_len, pass_cnt, fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import stable_mon_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic [WIDTH-1:0]      o_value
);
    logic [WIDTH-1:0] r_value;

    // Clear wins over increment; increment never wraps
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= WIDTH'(sat_inc(32'(r_value), WIDTH));
        end
    end

    assign o_value = r_value;
endmodule
`default_nettype wire

// File: rtl/stable_hold_monitor.sv
`default_nettype none
// ============================================================================
// Module      : stable_hold_monitor
// Description : Checks that a sampled signal stays unchanged for a programmed
//               number of consecutive cycles within a bounded window.
// Revision    : 1.0 - initial release
// ============================================================================
module stable_hold_monitor
    import stable_mon_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    stable_hold_monitor_if.slave  bus
);
    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_change;
    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_window;

    logic [CNT_W-1:0] w_run_len;
    logic [CNT_W-1:0] w_elapsed;
    logic [CNT_W-1:0] w_pass_cnt;
    logic [CNT_W-1:0] w_fail_cnt;
    logic [CNT_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_elapsed_next;
    logic             w_accept;
    logic             w_in_check;
    logic             w_stable;
    logic             w_hold_hit;
    logic             w_timeout;

    assign w_accept       = (r_state == S_IDLE) && bus.start;
    assign w_in_check     = (r_state == S_CHECK);
    assign w_stable       = (bus.sig == r_prev);
    // Both comparisons use the value the counter had before this edge, plus one
    assign w_run_next     = w_run_len + CNT_W'(1);
    assign w_elapsed_next = w_elapsed + CNT_W'(1);
    assign w_hold_hit     = w_stable && (w_run_next == r_hold);
    assign w_timeout      = (r_window != CNT_W'(c_WINDOW_UNLIMITED))
                            && (w_elapsed_next == r_window);

    // Sequencing FSM with registered status outputs; hold success beats timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_change <= 1'b0;
            r_prev   <= '0;
            r_hold   <= '0;
            r_window <= '0;
        end else begin
            r_done   <= 1'b0;
            r_change <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_hold   <= bus.hold_cycles;
                        r_window <= bus.window_cycles;
                        r_pass   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_prev <= bus.sig;
                    if (r_hold == '0) begin
                        r_pass  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_prev   <= bus.sig;
                    r_change <= ~w_stable;
                    if (w_hold_hit) begin
                        r_pass  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_run_len (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_in_check && w_stable),
        .i_clr   (w_accept || (w_in_check && !w_stable)),
        .o_value (w_run_len)
    );

    sat_counter #(.WIDTH(CNT_W)) u_elapsed (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_in_check),
        .i_clr   (w_accept),
        .o_value (w_elapsed)
    );

    sat_counter #(.WIDTH(CNT_W)) u_pass_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   ((r_state == S_DONE) && r_pass),
        .i_clr   (1'b0),
        .o_value (w_pass_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_in_check && !w_stable),
        .i_clr   (1'b0),
        .o_value (w_fail_cnt)
    );

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.pass         = r_pass;
    assign bus.change_pulse = r_change;
    assign bus.run_len      = w_run_len;
    assign bus.pass_cnt     = w_pass_cnt;
    assign bus.fail_cnt     = w_fail_cnt;
endmodule
`default_nettype wire

// File: doc/stable_hold_monitor.md
# stable_hold_monitor

Synthesizable stability monitor for a sampled signal. Once armed, it compares the signal against its previous-cycle value every clock. It declares pass when the signal holds for a programmed number of consecutive cycles inside a bounded observation window, and declares timeout otherwise. It sits beside the stimulus/DUT boundary in our assertion test benches and gives a hardware-countable result for hold requirements, with pass/fail tallies readable by the bench.

## Interface
- WIDTH, 1, width of monitored signal
- CNT_W, 8, width of hold/window configuration and all counters

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a check; honoured only in IDLE
- hold_cycles  in  CNT_W  consecutive stable comparisons required for pass; sampled on accepted start
- window_cycles  in  CNT_W  maximum comparisons before timeout; 0 = unlimited; sampled on accepted start
- sig  in  WIDTH  monitored signal, already synchronous to clk
- busy  out  1  high in ARM and CHECK
- done  out  1  one-cycle pulse when a check completes
- pass  out  1  result of last completed check; held until next accepted start
- change_pulse  out  1  one-cycle pulse in every CHECK cycle where sig differs from its previous value
- run_len  out  CNT_W  current consecutive-stable count
- pass_cnt  out  CNT_W  completed passing checks since reset, saturating
- fail_cnt  out  CNT_W  total detected changes since reset, saturating

## Operation
- States: IDLE, ARM, CHECK, DONE.
- IDLE: when start=1, latch hold_cycles and window_cycles, clear run_len, elapsed and pass, then go to ARM.
- ARM: capture prev <= sig. If latched hold=0, go to DONE with pass=1. Otherwise go to CHECK.
- CHECK, every cycle:
  - elapsed increments.
  - Stable is defined as sig == prev; then prev <= sig.
  - If stable, run_len increments.
  - If changed, run_len <= 0, change_pulse=1 and fail_cnt increments.
  - If run_len+1 == hold and stable, go to DONE with pass=1.
  - Else if window≠0 and elapsed+1 == window, go to DONE with pass=0.
- Simultaneous events: when the hold is reached on the final window comparison, pass takes priority.
- DONE: done=1 for exactly one cycle. pass_cnt increments if pass=1. Return to IDLE.
- start outside IDLE (ARM, CHECK, DONE) is ignored, with no queuing.
- Counters saturate at all-ones with no wrap. elapsed and run_len compare in CNT_W bits. Unlimited window never times out; run_len saturates.
- Reset:
  - rst=1 in any state forces IDLE on the next edge.
  - All outputs and internal registers go to 0: busy, done, pass, change_pulse, run_len, pass_cnt, fail_cnt, prev, elapsed.
  - An in-flight check is abandoned without asserting done.

## Timing
- All outputs are registered, except change_pulse, which is registered in the same cycle as the comparison result.
- start accepted at edge t: ARM during cycle t+1, first comparison at edge t+2.
- Fastest pass, hold=1, sig stable: done high in the cycle after edge t+2. Start-to-done latency is 3 cycles.
- General pass latency with no changes is hold+2 cycles from the start edge. Timeout latency is window+2.
- busy rises on the edge after start and falls on the edge that enters DONE. done and busy are never high together.
- Back-to-back checks: start may be reasserted in the first IDLE cycle after done, giving a 1-cycle minimum gap.

## Structure
- Shared package stable_mon_pkg holds:
  - state enum typedef (IDLE, ARM, CHECK, DONE)
  - saturating-increment function, parameterised by width
  - localparam for the unlimited-window encoding (0)
- One natural sub-module, sat_counter (width param, inc, clr, value), instantiated for pass_cnt, fail_cnt, run_len and elapsed.
- The FSM and the comparison stay in the top module.

## Test plan
- Constant sig=1, hold=4, window=10, start pulsed -> done 6 cycles after start edge, pass=1, pass_cnt=1, fail_cnt=0.
- sig toggles every cycle, hold=3, window=5 -> done at start+7, pass=0, change_pulse on all 5 comparisons, fail_cnt=5.
- sig stable 2 cycles, changes once, then stable, hold=3, window=6 -> run_len goes 1,2,0,1,2,3. Pass on the 6th comparison, exercising hold-on-last-window priority.
- hold=0 -> done at start+2, pass=1. window=0 with toggling sig for 300 cycles -> busy stays high, fail_cnt saturates at 255.
- start pulsed during CHECK -> ignored; exactly one done results.
- rst asserted mid-CHECK -> next cycle all outputs 0 and state IDLE, with no done pulse.
